dmem_arbiter: RTL and testbench

//  Shares the single data memory between the pipeline MEM stage (CPU port) and a loader/debug port.

---
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU MEM stage and a loader/debug port.
// The CPU has priority; a starvation counter and lockable loader bursts guarantee loader progress.
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_funct3,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_data_out
);
  // state  | meaning
  // S_OPEN | CPU has priority; loader forced in once starve_cnt reaches STARVE_MAX
  // S_LOCK | loader burst owns the memory; CPU is stalled
  typedef enum logic {S_OPEN = 1'b0, S_LOCK = 1'b1} state_t;

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [2:0]       F3_WORD = 3'b010;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              ld_rvalid_q;
  logic [DATA_W-1:0] ld_rdata_q;
  logic              ld_win, cpu_win;

  always_comb begin
    ld_win  = 1'b0;
    cpu_win = 1'b0;
    if (state_q == S_LOCK) begin
      ld_win = ld_req;
    end else begin
      ld_win  = ld_req && (!cpu_req || (starve_cnt_q == CNT_MAX));
      cpu_win = cpu_req && !ld_win;
    end
  end

  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_funct3   = '0;
    if (ld_win) begin
      mem_read_en  = !ld_we;
      mem_write_en = ld_we;
      mem_addr     = ld_addr;
      mem_data_in  = ld_wdata;
      mem_funct3   = F3_WORD;
    end else if (cpu_win) begin
      mem_read_en  = !cpu_we;
      mem_write_en = cpu_we;
      mem_addr     = cpu_addr;
      mem_data_in  = cpu_wdata;
      mem_funct3   = cpu_funct3;
    end
  end

  // cpu_win implies a contended cycle whenever ld_req is still high
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (ld_win || !ld_req) begin
      starve_cnt_d = '0;
    end else if (cpu_win && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    case (state_q)
      S_OPEN:  if (ld_win && ld_lock) state_d = S_LOCK;
      S_LOCK:  if ((ld_win && !ld_lock) || !ld_req) state_d = S_OPEN;
      default: state_d = S_OPEN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_OPEN;
      starve_cnt_q <= '0;
      ld_rvalid_q  <= 1'b0;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ld_rvalid_q  <= ld_win && !ld_we;
      if (ld_win && !ld_we) ld_rdata_q <= mem_data_out;
    end
  end

  assign cpu_stall = cpu_req && !cpu_win;
  assign cpu_rdata = mem_data_out;
  assign ld_gnt    = ld_win;
  assign ld_rvalid = ld_rvalid_q;
  assign ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic against a behavioural arbitration
// model and a shadow copy of the data memory.
module tb_dmem_arbiter;
  localparam int SMAX = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, ld_req, ld_we, ld_lock;
  logic [11:0] cpu_addr, ld_addr;
  logic [31:0] cpu_wdata, ld_wdata;
  logic [2:0]  cpu_funct3;
  logic        cpu_stall, ld_gnt, ld_rvalid, mem_read_en, mem_write_en;
  logic [31:0] cpu_rdata, ld_rdata, mem_data_in, mem_data_out;
  logic [11:0] mem_addr;
  logic [2:0]  mem_funct3;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_funct3(mem_funct3), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  // Data memory the arbiter drives: combinational read, write at the clock edge
  logic [31:0] mem [0:1023];
  assign mem_data_out = mem[mem_addr[11:2]];
  always @(posedge clock) if (mem_write_en) mem[mem_addr[11:2]] <= mem_data_in;

  int total = 0;
  int bad   = 0;

  // Reference model: shadow memory, burst flag, count of contended cycles lost by the loader
  logic [31:0] ref_mem [0:1023];
  bit          m_locked;
  int          m_streak;
  bit          m_rvalid;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit cr, input bit cwe, input logic [11:0] ca, input logic [31:0] cwd,
                       input logic [2:0] cf3, input bit lr, input bit lwe, input bit llk,
                       input logic [11:0] la, input logic [31:0] lwd);
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd; cpu_funct3 = cf3;
    ld_req = lr; ld_we = lwe; ld_lock = llk; ld_addr = la; ld_wdata = lwd;
  endtask

  task automatic model_reset();
    m_locked = 0; m_streak = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  // Called just after a rising edge with inputs already driven; returns just after the next edge.
  task automatic cycle(output bit e_ld, output bit e_cpu);
    bit          any, x_we;
    logic [11:0] x_addr;
    logic [31:0] x_wd, rd_word;
    logic [2:0]  x_f3;
    e_ld  = ld_req && (m_locked || !cpu_req || m_streak >= SMAX);
    e_cpu = !m_locked && cpu_req && !e_ld;
    any   = e_ld || e_cpu;
    x_we  = e_ld ? ld_we : (e_cpu ? cpu_we : 1'b0);
    x_addr = e_ld ? ld_addr : (e_cpu ? cpu_addr : 12'h0);
    x_wd   = e_ld ? ld_wdata : (e_cpu ? cpu_wdata : 32'h0);
    x_f3   = e_ld ? 3'b010 : (e_cpu ? cpu_funct3 : 3'b000);
    rd_word = ref_mem[x_addr[11:2]];
    #3;
    chk("ld_gnt", {31'b0, ld_gnt}, {31'b0, e_ld});
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req && !e_cpu});
    chk("mem_read_en", {31'b0, mem_read_en}, {31'b0, any && !x_we});
    chk("mem_write_en", {31'b0, mem_write_en}, {31'b0, any && x_we});
    chk("mem_addr", {20'b0, mem_addr}, {20'b0, x_addr});
    chk("mem_data_in", mem_data_in, x_wd);
    chk("mem_funct3", {29'b0, mem_funct3}, {29'b0, x_f3});
    if (e_cpu && !cpu_we) chk("cpu_rdata", cpu_rdata, rd_word);
    @(posedge clock);
    if (any && x_we) ref_mem[x_addr[11:2]] = x_wd;
    if (e_ld && !ld_we) begin m_rvalid = 1; m_rdata = rd_word; end
    else m_rvalid = 0;
    if (e_ld || !ld_req) m_streak = 0;
    else if (e_cpu) m_streak = (m_streak + 1 > SMAX) ? SMAX : m_streak + 1;
    if (!m_locked) m_locked = e_ld && ld_lock;
    else if ((e_ld && !ld_lock) || !ld_req) m_locked = 0;
    #1;
    chk("ld_rvalid", {31'b0, ld_rvalid}, {31'b0, m_rvalid});
    chk("ld_rdata", ld_rdata, m_rdata);
  endtask

  initial begin
    bit gl, gc;
    reset_n = 1'b0;
    drive(0, 0, 12'h0, 32'h0, 3'b0, 0, 0, 0, 12'h0, 32'h0);
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA5A50000 ^ (i * 32'h00010003);
      ref_mem[i] = 32'hA5A50000 ^ (i * 32'h00010003);
    end
    mem[12'h010 >> 2]     = 32'h12345678;
    ref_mem[12'h010 >> 2] = 32'h12345678;
    model_reset();
    @(posedge clock); #3;
    chk("rst_ld_rvalid", {31'b0, ld_rvalid}, 32'h0);
    chk("rst_ld_rdata", ld_rdata, 32'h0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 1: CPU read only
    drive(1, 0, 12'h010, 32'h0, 3'b010, 0, 0, 0, 12'h0, 32'h0);
    cycle(gl, gc);
    chk("t1_cpu_granted", {31'b0, gc}, 32'h1);

    // 2: loader write, then CPU reads it back
    drive(0, 0, 12'h0, 32'h0, 3'b0, 1, 1, 0, 12'h020, 32'hDEADBEEF);
    cycle(gl, gc);
    drive(1, 0, 12'h020, 32'h0, 3'b010, 0, 0, 0, 12'h0, 32'h0);
    #3 chk("t2_raw", cpu_rdata, 32'hDEADBEEF);
    #1 @(posedge clock); #1;

    // 3: continuous contention, loader forced in every fifth cycle
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 12'h040, 32'h0, 3'b010, 1, 0, 0, 12'h080, 32'h0);
      cycle(gl, gc);
      chk("t3_pattern", {31'b0, gl}, {31'b0, (i % 5) == 4});
    end

    // 4: locked three-word loader read burst while the CPU waits
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 12'h044, 32'h0, 3'b010, 1, 0, (i < 2), 12'h100 + 12'(4 * i), 32'h0);
      cycle(gl, gc);
      chk("t4_burst_gnt", {31'b0, gl}, 32'h1);
      chk("t4_burst_data", ld_rdata, ref_mem[(12'h100 >> 2) + i]);
    end
    drive(1, 0, 12'h044, 32'h0, 3'b010, 0, 0, 0, 12'h0, 32'h0);
    cycle(gl, gc);
    chk("t4_cpu_after", {31'b0, gc}, 32'h1);

    // 5: reset in the second cycle of a locked burst
    drive(0, 0, 12'h0, 32'h0, 3'b0, 1, 0, 1, 12'h200, 32'h0);
    cycle(gl, gc);
    drive(1, 0, 12'h048, 32'h0, 3'b010, 1, 0, 1, 12'h204, 32'h0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rvalid_async", {31'b0, ld_rvalid}, 32'h0);
    chk("t5_cpu_wins_in_reset", {31'b0, cpu_stall}, 32'h0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    drive(1, 0, 12'h048, 32'h0, 3'b010, 0, 0, 0, 12'h0, 32'h0);
    cycle(gl, gc);
    chk("t5_cpu_after_reset", {31'b0, gc}, 32'h1);

    // 6: idle
    drive(0, 0, 12'h0, 32'h0, 3'b0, 0, 0, 0, 12'h0, 32'h0);
    cycle(gl, gc);
    chk("t6_idle_rvalid", {31'b0, ld_rvalid}, 32'h0);

    // Random traffic over a small address window so read-after-write hits occur
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 12'($urandom_range(0, 31) << 2),
            $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            12'($urandom_range(0, 31) << 2), $urandom);
      cycle(gl, gc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
